mem_stage: RTL

Memory-access pipeline stage placed directly after the execute stage and before write-back. It receives the execute stage's results once the data-side request has been address-accepted, waits for the matching data response, and extracts and sign/zero-extends the loaded value. It passes the destination, PC and exception information to write-back and exports forwarding and hazard status to decode. It also tracks and discards responses that belong to requests cancelled by a pipeline flush.

---
 rtl/mem_stage.sv | 157 +++++++++++++++
 1 files changed

// File: rtl/mem_stage.sv
// Memory-access pipeline stage: waits for the data response, extracts the load value,
// forwards results to write-back and drops responses of flushed requests.
module mem_stage #(
    parameter logic [31:0] PC_RESET = 32'h1bfffffc,
    parameter int unsigned EXC_W    = 8
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             ex_to_mem_valid,
    output logic             mem_allowin,
    input  logic [31:0]      alu_result_i,
    input  logic             res_from_mem_i,
    input  logic             st_req_i,
    input  logic [2:0]       ld_type_i,
    input  logic             gr_we_i,
    input  logic [4:0]       dest_i,
    input  logic [31:0]      pc_i,
    input  logic [EXC_W-1:0] exc_i,
    input  logic             ertn_i,
    input  logic             ex_req_fire,
    input  logic             data_data_ok,
    input  logic [31:0]      data_rdata,
    input  logic             flush,
    input  logic             wb_allowin,
    output logic             mem_to_wb_valid,
    output logic [31:0]      final_result,
    output logic             gr_we_o,
    output logic [4:0]       dest_o,
    output logic [31:0]      pc_o,
    output logic [EXC_W-1:0] exc_o,
    output logic             ertn_o,
    output logic             mem_exc,
    output logic             mem_valid,
    output logic [4:0]       mem_fwd_dest,
    output logic             mem_ld_wait
);

    logic [31:0]      alu_result;
    logic             res_from_mem;
    logic             st_req;
    logic [2:0]       ld_type;
    logic             gr_we;
    logic [4:0]       dest;
    logic [31:0]      pc;
    logic [EXC_W-1:0] exc;
    logic             ertn;

    logic             got_data;
    logic [31:0]      data_buf;
    logic [1:0]       discard_cnt;

    logic             need_resp;
    logic             resp_ok;
    logic             mem_readygo;
    logic             accept;
    logic             leave;
    logic             capture;
    logic             inc_cur;
    logic             inc_ex;
    logic             dec;
    logic [2:0]       cnt_sum;
    logic [1:0]       cnt_next;
    logic [31:0]      rdata;
    logic [7:0]       rbyte;
    logic [15:0]      rhalf;
    logic [31:0]      ld_value;

    assign need_resp       = mem_valid & (res_from_mem | st_req);
    // A response only belongs to this stage once all stale ones have been drained.
    assign resp_ok         = data_data_ok & (discard_cnt == 2'd0);
    assign mem_readygo     = !need_resp | got_data | resp_ok;
    assign mem_allowin     = !mem_valid | (mem_readygo & wb_allowin);
    assign mem_to_wb_valid = mem_valid & mem_readygo;
    assign accept          = ex_to_mem_valid & mem_allowin;
    assign leave           = mem_to_wb_valid & wb_allowin;
    assign capture         = resp_ok & need_resp & !got_data & !wb_allowin;

    assign inc_cur  = flush & need_resp & !got_data & !resp_ok;
    assign inc_ex   = flush & ex_req_fire;
    assign dec      = data_data_ok & (discard_cnt != 2'd0);
    assign cnt_sum  = {1'b0, discard_cnt} + {2'b00, inc_cur} + {2'b00, inc_ex} - {2'b00, dec};
    assign cnt_next = (cnt_sum > 3'd3) ? 2'd3 : cnt_sum[1:0];

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_valid    <= 1'b0;
            got_data     <= 1'b0;
            data_buf     <= '0;
            discard_cnt  <= '0;
            alu_result   <= '0;
            res_from_mem <= 1'b0;
            st_req       <= 1'b0;
            ld_type      <= '0;
            gr_we        <= 1'b0;
            dest         <= '0;
            pc           <= PC_RESET;
            exc          <= '0;
            ertn         <= 1'b0;
        end else begin
            discard_cnt <= cnt_next;

            if (flush)
                mem_valid <= 1'b0;
            else if (mem_allowin)
                mem_valid <= ex_to_mem_valid;

            if (accept) begin
                alu_result   <= alu_result_i;
                res_from_mem <= res_from_mem_i;
                st_req       <= st_req_i;
                ld_type      <= ld_type_i;
                gr_we        <= gr_we_i;
                dest         <= dest_i;
                pc           <= pc_i;
                exc          <= exc_i;
                ertn         <= ertn_i;
            end

            if (flush || accept || leave)
                got_data <= 1'b0;
            else if (capture)
                got_data <= 1'b1;

            if (capture)
                data_buf <= data_rdata;
        end
    end

    always_comb begin
        rdata = got_data ? data_buf : data_rdata;
        case (alu_result[1:0])
            2'd0:    rbyte = rdata[7:0];
            2'd1:    rbyte = rdata[15:8];
            2'd2:    rbyte = rdata[23:16];
            default: rbyte = rdata[31:24];
        endcase
        rhalf = alu_result[1] ? rdata[31:16] : rdata[15:0];
        case (ld_type)
            3'd2:    ld_value = {{24{rbyte[7]}}, rbyte};
            3'd3:    ld_value = {{16{rhalf[15]}}, rhalf};
            3'd4:    ld_value = {24'd0, rbyte};
            3'd5:    ld_value = {16'd0, rhalf};
            default: ld_value = rdata;
        endcase
    end

    assign final_result = res_from_mem ? ld_value : alu_result;
    assign gr_we_o      = gr_we & ~(|exc);
    assign dest_o       = dest;
    assign pc_o         = pc;
    assign exc_o        = exc;
    assign ertn_o       = ertn;
    assign mem_exc      = mem_valid & ((|exc) | ertn);
    assign mem_fwd_dest = (mem_valid & gr_we_o) ? dest : 5'd0;
    assign mem_ld_wait  = mem_valid & res_from_mem & !mem_readygo;

endmodule
